// File: rtl/addsub_pipe_if.sv
// Operand/result stream bundle for addsub_pipe.
// master: operand producer plus result consumer; slave: the pipeline itself.
interface addsub_pipe_if #(
   parameter int unsigned WIDTH = 4
);
   logic             in_valid;
   logic             in_ready;
   logic [WIDTH-1:0] a;
   logic [WIDTH-1:0] b;
   logic             sel_add1_sub0;
   logic             signed_mode;
   logic             out_valid;
   logic             out_ready;
   logic [WIDTH-1:0] sum_diff;
   logic             carry_borrow_out;
   logic             overflow;
   logic             zero;

   modport master (
      output in_valid, a, b, sel_add1_sub0, signed_mode, out_ready,
      input  in_ready, out_valid, sum_diff, carry_borrow_out, overflow, zero
   );

   modport slave (
      input  in_valid, a, b, sel_add1_sub0, signed_mode, out_ready,
      output in_ready, out_valid, sum_diff, carry_borrow_out, overflow, zero
   );
endinterface

// File: rtl/addsub_pipe.sv
// Two-stage pipelined adder/subtractor with valid/ready handshake and
// carry/borrow, overflow and zero flags.
// Optional clamp-on-overflow build: define ADDSUB_SATURATE_EN.
module addsub_pipe #(
   parameter int unsigned WIDTH = 4
) (
   input logic          clk,
   input logic          rst,
   addsub_pipe_if.slave bus
);

   logic             ready_en_q;
   logic             s1_valid_q;
   logic [WIDTH-1:0] s1_a_q;
   logic [WIDTH-1:0] s1_b_q;
   logic             s1_add_q;
   logic             s1_sgn_q;
   logic             s2_valid_q;
   logic [WIDTH-1:0] s2_sum_q;
   logic             s2_cb_q;
   logic             s2_ov_q;
   logic             s2_zero_q;

   logic             s1_load;
   logic             s2_load;
   logic [WIDTH-1:0] b_eff;
   logic [WIDTH:0]   raw;
   logic             cb;
   logic             ov;
   logic [WIDTH-1:0] res;

   // S2 takes S1 whenever it is empty or its result leaves this cycle.
   assign s2_load      = s1_valid_q && (!s2_valid_q || bus.out_ready);
   assign bus.in_ready = ready_en_q && (!s1_valid_q || s2_load);
   assign s1_load      = bus.in_valid && bus.in_ready;

   assign bus.out_valid        = s2_valid_q;
   assign bus.sum_diff         = s2_sum_q;
   assign bus.carry_borrow_out = s2_cb_q;
   assign bus.overflow         = s2_ov_q;
   assign bus.zero             = s2_zero_q;

   // Hold off in_ready until the first clock edge after reset release.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         ready_en_q <= 1'b0;
      end else begin
         ready_en_q <= 1'b1;
      end
   end

   // Stage 1: capture the operand bundle on input transfer.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         s1_valid_q <= 1'b0;
         s1_a_q     <= '0;
         s1_b_q     <= '0;
         s1_add_q   <= 1'b0;
         s1_sgn_q   <= 1'b0;
      end else begin
         if (s1_load) begin
            s1_a_q   <= bus.a;
            s1_b_q   <= bus.b;
            s1_add_q <= bus.sel_add1_sub0;
            s1_sgn_q <= bus.signed_mode;
         end
         if (s1_load) begin
            s1_valid_q <= 1'b1;
         end else if (s2_load) begin
            s1_valid_q <= 1'b0;
         end
      end
   end

   // Arithmetic on WIDTH+1 bits; subtraction as A + ~B + 1.
   always_comb begin
      b_eff = s1_add_q ? s1_b_q : ~s1_b_q;
      raw   = {1'b0, s1_a_q} + {1'b0, b_eff} + {{WIDTH{1'b0}}, ~s1_add_q};
      cb    = s1_add_q ? raw[WIDTH] : ~raw[WIDTH];
      if (s1_sgn_q) begin
         ov = (s1_a_q[WIDTH-1] == b_eff[WIDTH-1]) && (raw[WIDTH-1] != s1_a_q[WIDTH-1]);
      end else begin
         ov = cb;
      end
      res = raw[WIDTH-1:0];
`ifdef ADDSUB_SATURATE_EN
      // Signed overflow direction follows the sign shared by A and effective B.
      if (ov) begin
         if (!s1_sgn_q) begin
            res = s1_add_q ? '1 : '0;
         end else if (!s1_a_q[WIDTH-1]) begin
            res = {1'b0, {(WIDTH-1){1'b1}}};
         end else begin
            res = {1'b1, {(WIDTH-1){1'b0}}};
         end
      end
`endif
   end

   // Stage 2: register result and flags; hold them while stalled.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         s2_valid_q <= 1'b0;
         s2_sum_q   <= '0;
         s2_cb_q    <= 1'b0;
         s2_ov_q    <= 1'b0;
         s2_zero_q  <= 1'b0;
      end else if (s2_load) begin
         s2_valid_q <= 1'b1;
         s2_sum_q   <= res;
         s2_cb_q    <= cb;
         s2_ov_q    <= ov;
         s2_zero_q  <= (res == '0);
      end else if (bus.out_ready) begin
         s2_valid_q <= 1'b0;
      end
   end

endmodule
